// File: rtl/adr_regfile_mp.sv
// Multi-port integer register file: NUM_WR write ports, NUM_RD registered read ports,
// hardwired-zero x0, highest-index write priority and optional same-cycle write forwarding.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 5
`endif

module adr_regfile_rdport #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en_i,
  input  logic [AW-1:0]                  addr_i,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  mem_i,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data_i,
  output logic [XLEN-1:0]                data_o
);
  logic [XLEN-1:0] data_d, data_q;

  // Ascending scan lets the highest-index matching write win the forward.
  always_comb begin
    data_d = mem_i[addr_i];
    if (BYPASS != 0)
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en_i[w] && (wr_addr_i[w] == addr_i)) data_d = wr_data_i[w];
    if (addr_i == '0) data_d = '0;
  end

  always_ff @(posedge clk)
    if (!reset)    data_q <= '0;
    else if (en_i) data_q <= data_d;

  assign data_o = data_q;
endmodule

module adr_regfile_mp #(
  parameter int XLEN     = `XLEN,
  parameter int NUM_REGS = 32,
  parameter int AW       = `REG_ADDR_LEN,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        read_en_i,
  input  logic [NUM_RD*AW-1:0]     read_addr_i,
  output logic [NUM_RD*XLEN-1:0]   read_data_o,
  input  logic [NUM_WR-1:0]        write_en_i,
  input  logic [NUM_WR*AW-1:0]     write_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   write_data_i
);
  logic [NUM_RD-1:0][AW-1:0]       ra;
  logic [NUM_RD-1:0][XLEN-1:0]     rd;
  logic [NUM_WR-1:0][AW-1:0]       wa;
  logic [NUM_WR-1:0][XLEN-1:0]     wd;
  logic [NUM_REGS-1:0][XLEN-1:0]   mem_d, mem_q;

  assign ra          = read_addr_i;
  assign wa          = write_addr_i;
  assign wd          = write_data_i;
  assign read_data_o = rd;

  // Later ports overwrite earlier ones; entry 0 is forced back to zero afterwards.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++)
      if (write_en_i[w]) mem_d[wa[w]] = wd[w];
    mem_d[0] = '0;
  end

  always_ff @(posedge clk)
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    adr_regfile_rdport #(
      .XLEN(XLEN), .NUM_REGS(NUM_REGS), .AW(AW), .NUM_WR(NUM_WR), .BYPASS(BYPASS)
    ) u_rd (
      .clk      (clk),
      .reset    (reset),
      .en_i     (read_en_i[p]),
      .addr_i   (ra[p]),
      .mem_i    (mem_q),
      .wr_en_i  (write_en_i),
      .wr_addr_i(wa),
      .wr_data_i(wd),
      .data_o   (rd[p])
    );
  end
endmodule

// File: tb/tb_adr_regfile_mp.sv
// Scoreboard bench: two register files (forwarding on / off) share stimulus; a spec-level
// model pushes expected read outputs per edge and a monitor pops and compares them.
module tb_adr_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ren;
  logic [9:0]  raddr;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [63:0] rd_b, rd_n;

  always #5 clk = ~clk;

  adr_regfile_mp #(.XLEN(32), .NUM_REGS(32), .AW(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_b (
    .clk(clk), .reset(rst_n), .read_en_i(ren), .read_addr_i(raddr), .read_data_o(rd_b),
    .write_en_i(wen), .write_addr_i(waddr), .write_data_i(wdata));
  adr_regfile_mp #(.XLEN(32), .NUM_REGS(32), .AW(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_n (
    .clk(clk), .reset(rst_n), .read_en_i(ren), .read_addr_i(raddr), .read_data_o(rd_n),
    .write_en_i(wen), .write_addr_i(waddr), .write_data_i(wdata));

  typedef struct {
    logic [31:0] b [2];
    logic [31:0] n [2];
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] regs  [32];
  logic [31:0] out_b [2];
  logic [31:0] out_n [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: register array + last output per port, evaluated from the current inputs.
  task automatic model_edge();
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
      for (int p = 0; p < 2; p++) begin out_b[p] = '0; out_n[p] = '0; end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) begin
          int a = int'(raddr[p*5 +: 5]);
          logic [31:0] v = regs[a];
          logic [31:0] f = regs[a];
          for (int w = 0; w < 2; w++)
            if (wen[w] && int'(waddr[w*5 +: 5]) == a) f = wdata[w*32 +: 32];
          out_n[p] = (a == 0) ? 32'h0 : v;
          out_b[p] = (a == 0) ? 32'h0 : f;
        end
      end
      for (int w = 0; w < 2; w++)
        if (wen[w] && waddr[w*5 +: 5] != 5'd0) regs[int'(waddr[w*5 +: 5])] = wdata[w*32 +: 32];
    end
    for (int p = 0; p < 2; p++) begin e.b[p] = out_b[p]; e.n[p] = out_n[p]; end
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [1:0] we, input logic [4:0] w0a, input logic [4:0] w1a,
                     input logic [31:0] w0d, input logic [31:0] w1d);
    rst_n = r; ren = re; raddr = {a1, a0};
    wen = we; waddr = {w1a, w0a}; wdata = {w1d, w0d};
    model_edge();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("byp_rd0",   rd_b[31:0],  e.b[0]);
      check("byp_rd1",   rd_b[63:32], e.b[1]);
      check("nobyp_rd0", rd_n[31:0],  e.n[0]);
      check("nobyp_rd1", rd_n[63:32], e.n[1]);
    end
  end

  initial begin
    rst_n = 1'b0; ren = '0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
    #2;
    cyc(0, 2'b11, 5, 5, 2'b01, 5, 0, 32'hDEAD_BEEF, 0);
    cyc(0, 2'b11, 5, 5, 2'b01, 5, 0, 32'hDEAD_BEEF, 0);
    for (int i = 1; i < 32; i++) cyc(1, 2'b00, 0, 0, 2'b01, 5'(i), 0, 32'h0101_0101 * i, 0);
    cyc(1, 2'b11, 5, 6, 2'b00, 0, 0, 0, 0);
    // reset wins over a write presented at the same edge
    cyc(0, 2'b11, 5, 5, 2'b01, 5, 0, 32'hDEAD_BEEF, 0);
    for (int i = 1; i < 32; i++) cyc(1, 2'b11, 5'(i), 5'(32 - i), 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 2'b01, 7, 0, 32'h1234_5678, 0);
    cyc(1, 2'b11, 7, 7, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b11, 0, 0, 2'b11, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc(1, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 2'b01, 3, 0, 32'h11, 0);
    cyc(1, 2'b01, 3, 0, 2'b01, 3, 0, 32'h22, 0);
    cyc(1, 2'b01, 3, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b11, 9, 9, 2'b11, 9, 9, 32'hAAAA, 32'hBBBB);
    cyc(1, 2'b11, 9, 9, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 2'b01, 4, 0, 32'h44, 0);
    cyc(1, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b00, 6, 0, 2'b01, 4, 0, 32'h99, 0);
    cyc(1, 2'b00, 6, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 2'b01, 4, 0, 2'b00, 0, 0, 0, 0);
    // narrow address range to provoke write/write and write/read collisions
    for (int k = 0; k < 400; k++) begin
      logic [4:0] mask;
      mask = ($urandom_range(0, 1) == 1) ? 5'h07 : 5'h1F;
      cyc(($urandom_range(0, 49) != 0), 2'($urandom), 5'($urandom) & mask, 5'($urandom) & mask,
          2'($urandom), 5'($urandom) & mask, 5'($urandom) & mask, $urandom, $urandom);
    end
    cyc(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adr_regfile_mp.md
# adr_regfile_mp

Parametrised multi-port integer register file for the ADR core, the next generation of the single-write, dual-read register file. It adds configurable width, depth, read-port count and write-port count. It also adds per-port write and read enables, hardwired-zero x0, deterministic multi-write priority, optional write-to-read bypass and full synchronous clear. It sits between decode (read ports, registered operand fetch) and writeback (write ports).

## Interface
- XLEN, default `XLEN (32): data width in bits.
- NUM_REGS, default 32: register count, power of two, ≥2.
- AW, default `REG_ADDR_LEN (5): address width, $clog2(NUM_REGS).
- NUM_RD, default 2: read ports, 1..4.
- NUM_WR, default 1: write ports, 1..2.
- BYPASS, default 1: 1 = a same-cycle write is forwarded to the read output; 0 = the read returns the pre-write value.
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- read_en_i  in  NUM_RD  per-port read enable.
- read_addr_i  in  NUM_RD*AW  port p address at [p*AW +: AW].
- read_data_o  out  NUM_RD*XLEN  port p data at [p*XLEN +: XLEN], registered.
- write_en_i  in  NUM_WR  per-port write enable.
- write_addr_i  in  NUM_WR*AW  port w address at [w*AW +: AW].
- write_data_i  in  NUM_WR*XLEN  port w data at [w*XLEN +: XLEN].

## Operation
- Storage: NUM_REGS × XLEN flops. Entry 0 is constant zero. Writes to address 0 are discarded and reads of address 0 return 0 regardless of BYPASS.
- Write: on posedge with reset high and write_en_i[w]=1 and write_addr_i[w]≠0, the entry is loaded with write_data_i[w].
- Write conflict: if several enabled ports target the same address, the highest-index port wins. Other addresses are written independently.
- Read: on posedge with reset high and read_en_i[p]=1, read_data_o[p] loads the selected value. With read_en_i[p]=0 the output holds its previous value (operand stall).
- Read value selection, per port:
  - Address 0 returns 0.
  - Otherwise, if BYPASS=1 and any enabled write port targets the same address this edge, the output takes that write's data, using the same highest-index priority.
  - Otherwise the output takes the stored entry value.
- Multiple read ports may target the same address; each resolves independently and identically.
- Reset (reset=0 at posedge): all entries and all read_data_o clear to 0.
  - Writes and reads presented in that cycle are ignored.
  - Reset asserted mid-operation overrides any pending write at that edge.
- Out-of-range addresses are unreachable because NUM_REGS = 2^AW.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and data is valid after edge N.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1 for any BYPASS, and at edge N when BYPASS=1.
- Reset values: every read_data_o = 0 and every entry = 0 after the first edge with reset=0.
- First edge with reset=1 after release performs normal reads and writes.
- No combinational path from inputs to outputs.

## Test plan
- Reset: fill registers, hold reset=0 one cycle with write_en_i=1 to r5 (0xDEAD_BEEF) → all read_data_o=0. After release, reads of r1..r31 return 0 and r5≠0xDEAD_BEEF.
- Basic write/read: write r7=0x1234_5678 at edge N, read r7 on port 0 at edge N+1 → read_data_o[0]=0x1234_5678 after edge N+1. Port 1 reading r7 simultaneously returns the same value.
- x0: write r0=0xFFFF_FFFF, then read r0 on all ports with BYPASS=1 and BYPASS=0 → all return 0x0000_0000.
- Bypass: r3 holds 0x11. In the same cycle write r3=0x22 and read r3.
  - BYPASS=1 → output 0x22.
  - BYPASS=0 → output 0x11, then 0x22 on the next read.
- Write conflict (NUM_WR=2): port 0 writes r9=0xAAAA and port 1 writes r9=0xBBBB in the same cycle → subsequent read of r9 = 0xBBBB. With BYPASS=1 the same-cycle read also = 0xBBBB.
- Read hold: read r4 (0x44) with read_en_i[0]=1. Then hold read_en_i[0]=0 while changing read_addr_i to r6 and writing r4=0x99 → read_data_o[0] stays 0x44 until read_en_i[0] is reasserted.
